wb_pipe_master: RTL
===================

Name: wb_pipe_master

Overview:
- Wishbone B4 pipelined master: the initiator end that drives the single-master interconnect's master port.
- Turns a simple valid/ready command stream from the MCU-side logic into pipelined wishbone requests, tracks outstanding requests, and returns in-order responses.
- Sits between a command source (e.g. a debug/UART bridge) and the interconnect's wbm_* port.

Parameters:
- MAX_OUTSTANDING, 4, maximum requests issued but not yet acked (range 1..15).
- TIMEOUT_CYCLES, 1024, cycles without ack before abort (used only with the optional feature).

Ports:
- wb_clk_i  in  1  single clock, rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-low (0 = in reset).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  32  address.
- cmd_sel  in  4  byte select.
- cmd_dat  in  32  write data.
- rsp_valid  out  1  one-cycle response strobe; no backpressure.
- rsp_we  out  1  direction of the completed request.
- rsp_dat  out  32  read data (0 for writes).
- rsp_err  out  1  request aborted by timeout.
- wbm_cyc_o  out  1  cycle.
- wbm_stb_o  out  1  strobe.
- wbm_we_o  out  1  write enable.
- wbm_adr_o  out  32  address.
- wbm_sel_o  out  4  byte select.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data.
- wbm_stall_i  in  1  slave stall.
- wbm_ack_i  in  1  slave ack.

Behaviour:
- Reset: all outputs 0 immediately, including cmd_ready; issued counter, we-FIFO and timeout counter cleared. Reset mid-cycle drops cyc/stb asynchronously; acks arriving after release are ignored while cyc_o = 0.
- Request register: a command accepted at edge N drives stb_o = 1 with we/adr/sel/dat in cycle N+1. cyc_o rises in the same cycle as the first stb_o.
- Issue: the request is consumed on a rising edge where stb_o && !stall_i. On that edge issued is incremented, the we bit is pushed into an in-order FIFO of depth MAX_OUTSTANDING, and stb_o drops unless a new command is accepted on the same edge (back-to-back, one request per cycle).
- cmd_ready = (!stb_o || !stall_i) && (issued + stb_o < MAX_OUTSTANDING) && state != ABORT. Conservative: a slot freed by an ack is usable on the next cycle.
- Ack: when cyc_o && ack_i && issued > 0, the next cycle has rsp_valid = 1, rsp_we = FIFO head, rsp_dat = dat_i if read else 0, rsp_err = 0. The FIFO is popped and issued decremented.
- Issue and ack on the same edge leave issued unchanged; the FIFO pushes and pops together.
- Ack with issued = 0, or with cyc_o = 0: ignored, no response.
- Counter width: clog2(MAX_OUTSTANDING+1); issued never exceeds MAX_OUTSTANDING or wraps.
- States:
  - IDLE (cyc 0) -> BUSY on command accept.
  - BUSY -> IDLE on the edge where issued becomes 0, stb_o is not held, and no command is accepted; cyc_o drops in the following cycle.
  - BUSY -> ABORT on timeout (optional feature only).
  - ABORT -> IDLE after one cycle.
- wbm_dat_o/adr/sel/we hold their last value when stb_o = 0; they are don't-care for checking.

Optional Feature:
- Macro WB_PIPE_MASTER_TIMEOUT_EN.
- When defined, a counter runs in BUSY while issued > 0 or stb_o = 1. It clears on every ack or issue. When it reaches TIMEOUT_CYCLES:
  - enter ABORT: cyc_o and stb_o drop, issued and the FIFO clear, and any pending stb request is discarded;
  - a single rsp_valid with rsp_err = 1 and rsp_dat = 0 is emitted covering all aborted requests;
  - return to IDLE the next cycle.
- When not defined, there is no counter and no ABORT state, rsp_err is tied 0, and the master waits indefinitely.

Test Plan:
- Single write: cmd adr=0x10, dat=0xDEADBEEF, sel=0xF, we=1; slave acks 1 cycle after issue -> one stb cycle with those values, rsp_valid, rsp_we=1, rsp_dat=0, cyc_o low the cycle after rsp.
- Single read: cmd read adr=0x20; slave returns 0x12345678 with ack after 3 cycles -> rsp_dat=0x12345678, rsp_we=0, exactly one rsp_valid.
- Pipelined mixed: 4 back-to-back cmds R,W,R,R with stall_i high for 2 cycles on the 2nd -> stb held stable during stall, responses in order with rsp_we=0,1,0,0, cyc_o continuous.
- Backpressure: MAX_OUTSTANDING=4, slave never acks -> cmd_ready=0 after 4 issues; a single ack -> exactly one more command accepted.
- Timeout (macro on, TIMEOUT_CYCLES=16): 2 reads issued, no ack -> after 16 cycles cyc_o=0, one rsp with rsp_err=1, cmd_ready=1 next cycle; a late ack produces no response.
- Reset mid-operation: wb_rst_i=0 while 3 outstanding -> outputs 0 without waiting for a clock edge; after release a new read completes normally with issued starting at 0.

Source files
------------

// File: rtl/wb_pipe_master.sv
// Wishbone B4 pipelined master: valid/ready commands in, pipelined requests out, in-order responses.
// Optional watchdog abort enabled by defining WB_PIPE_MASTER_TIMEOUT_EN.
module wb_pipe_master #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    output logic        rsp_we,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_stall_i,
    input  logic        wbm_ack_i
);
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

`ifdef WB_PIPE_MASTER_TIMEOUT_EN
    typedef enum logic [1:0] {StIdle, StBusy, StAbort} state_e;
`else
    typedef enum logic [0:0] {StIdle, StBusy} state_e;
`endif

    state_e                     state_q, state_d;
    logic                       stb_q, stb_d;
    logic                       we_q;
    logic [31:0]                adr_q;
    logic [3:0]                 sel_q;
    logic [31:0]                dat_q;
    logic [CntW-1:0]            issued_q, issued_d, wr_idx;
    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic                       rsp_we_q, rsp_we_d;
    logic                       rsp_err_q, rsp_err_d;
    logic [31:0]                rsp_dat_q, rsp_dat_d;
    logic                       accept, issue, ack_ok, slot_free, abort_now, in_abort;

    assign issue     = stb_q && !wbm_stall_i;
    assign ack_ok    = (state_q == StBusy) && wbm_ack_i && (issued_q != '0);
    assign slot_free = (32'(issued_q) + 32'(stb_q)) < MAX_OUTSTANDING;
    // Gated by reset so the handshake is dead while the block is held in reset.
    assign cmd_ready = wb_rst_i && (!stb_q || !wbm_stall_i) && slot_free && !in_abort && !abort_now;
    assign accept    = cmd_valid && cmd_ready;

`ifdef WB_PIPE_MASTER_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            tmo_run;

    always_comb begin
        tmo_run   = (state_q == StBusy) && ((issued_q != '0) || stb_q);
        abort_now = tmo_run && !issue && !ack_ok && (32'(tmo_q) >= TIMEOUT_CYCLES - 1);
        tmo_d     = (!tmo_run || issue || ack_ok) ? '0 : tmo_q + TmoW'(1);
        in_abort  = (state_q == StAbort);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign abort_now = 1'b0;
    assign in_abort  = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        stb_d    = stb_q;
        if (issue) stb_d = 1'b0;
        if (accept) stb_d = 1'b1;
        issued_d = issued_q + CntW'(issue) - CntW'(ack_ok);
        // Head of the we FIFO lives at bit 0; a push lands behind whatever survives the pop.
        wr_idx   = issued_q - CntW'(ack_ok);
        fifo_d   = ack_ok ? (fifo_q >> 1) : fifo_q;
        for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
            if (issue && (i == int'(wr_idx))) fifo_d[i] = we_q;
        end
        rsp_valid_d = ack_ok;
        rsp_we_d    = ack_ok && fifo_q[0];
        rsp_dat_d   = (ack_ok && !fifo_q[0]) ? wbm_dat_i : '0;
        rsp_err_d   = 1'b0;

        case (state_q)
            StIdle: if (accept) state_d = StBusy;
            StBusy: if ((issued_d == '0) && !stb_d) state_d = StIdle;
`ifdef WB_PIPE_MASTER_TIMEOUT_EN
            StAbort: state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase

`ifdef WB_PIPE_MASTER_TIMEOUT_EN
        // One error response stands in for every request dropped by the abort.
        if (abort_now) begin
            state_d     = StAbort;
            stb_d       = 1'b0;
            issued_d    = '0;
            fifo_d      = '0;
            rsp_valid_d = 1'b1;
            rsp_we_d    = 1'b0;
            rsp_dat_d   = '0;
            rsp_err_d   = 1'b1;
        end
`endif
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q     <= StIdle;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            sel_q       <= '0;
            dat_q       <= '0;
            issued_q    <= '0;
            fifo_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stb_q       <= stb_d;
            issued_q    <= issued_d;
            fifo_q      <= fifo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            if (accept) begin
                we_q  <= cmd_we;
                adr_q <= cmd_adr;
                sel_q <= cmd_sel;
                dat_q <= cmd_dat;
            end
        end
    end

    assign wbm_cyc_o = (state_q == StBusy);
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_sel_o = sel_q;
    assign wbm_dat_o = dat_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;

endmodule
